// File: rtl/map_tile_fetch.sv
// Maze tile fetch: maps a screen pixel to its maze tile, drives the sprite ROM
// select lines and registers the returned colour through a three-stage pipeline.
module map_tile_fetch #(
    parameter int unsigned MAP_COLS   = 28,
    parameter int unsigned MAP_ROWS   = 31,
    parameter int unsigned MAP_X0     = 208,
    parameter int unsigned MAP_Y0     = 116,
    parameter int unsigned BLANK_TILE = 6,
    parameter int unsigned AW         = 10
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [9:0]    pixel_x_i,
    input  logic [9:0]    pixel_y_i,
    input  logic          pixel_valid_i,
    input  logic          tile_we_i,
    input  logic [AW-1:0] tile_waddr_i,
    input  logic [8:0]    tile_wdata_i,
    output logic [4:0]    grid_select_o,
    output logic [1:0]    rotate_select_o,
    output logic [1:0]    mirror_select_o,
    output logic [2:0]    x_index_o,
    output logic [2:0]    y_index_o,
    input  logic [11:0]   map_color_i,
    output logic [11:0]   rgb_out_o,
    output logic          rgb_valid_o
);

    localparam int unsigned   DEPTH    = MAP_COLS * MAP_ROWS;
    localparam logic [31:0]   DEPTH_W  = 32'(DEPTH);
    localparam logic [31:0]   COLS_W   = 32'(MAP_COLS);
    localparam logic [31:0]   ROWS_W   = 32'(MAP_ROWS);
    localparam logic [9:0]    X0       = 10'(MAP_X0);
    localparam logic [9:0]    Y0       = 10'(MAP_Y0);
    localparam logic [AW-1:0] COLS_AW  = AW'(MAP_COLS);
    localparam logic [4:0]    BLANK    = 5'(BLANK_TILE);

    // S0 combinational signals
    logic [9:0]    dx_s;
    logic [9:0]    dy_s;
    logic [6:0]    col_s;
    logic [6:0]    row_s;
    logic          in_map_s;
    logic [AW-1:0] addr_s;
    logic [AW-1:0] rd_addr_s;
    logic          wr_ok_s;

    // Tile RAM and S0 registers
    logic [8:0]    tile_mem [DEPTH];
    logic [8:0]    rd_word_q;
    logic [2:0]    fx_q;
    logic [2:0]    fy_q;
    logic          in_map0_q;
    logic          valid0_q;

    // S1 registers and next state
    logic [4:0]    grid_q,  grid_d;
    logic [1:0]    rot_q,   rot_d;
    logic [1:0]    mir_q,   mir_d;
    logic [2:0]    xi_q,    xi_d;
    logic [2:0]    yi_q,    yi_d;
    logic          in_map1_q;
    logic          valid1_q;

    // S2 registers and next state
    logic [11:0]   rgb_q,   rgb_d;
    logic          rgbv_q;

    // Pixel-to-tile decode; negative offsets are rejected by the >= compares
    always_comb begin
        dx_s     = pixel_x_i - X0;
        dy_s     = pixel_y_i - Y0;
        col_s    = dx_s[9:3];
        row_s    = dy_s[9:3];
        in_map_s = pixel_valid_i
                 && (pixel_x_i >= X0)
                 && (pixel_y_i >= Y0)
                 && (32'(col_s) < COLS_W)
                 && (32'(row_s) < ROWS_W);
        addr_s   = AW'(row_s) * COLS_AW + AW'(col_s);
        wr_ok_s  = tile_we_i && (32'(tile_waddr_i) < DEPTH_W);
        if (in_map_s) begin
            rd_addr_s = addr_s;
        end else begin
            rd_addr_s = {AW{1'b0}};
        end
    end

    // Tile RAM write port; contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
            tile_mem[tile_waddr_i] <= tile_wdata_i;
        end
    end

    // Tile RAM read port; nonblocking semantics give read-first on collisions
    always_ff @(posedge clk_i) begin
        rd_word_q <= tile_mem[rd_addr_s];
    end

    // S0 pipeline register: fine offsets within the tile and qualifiers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fx_q      <= 3'd0;
            fy_q      <= 3'd0;
            in_map0_q <= 1'b0;
            valid0_q  <= 1'b0;
        end else begin
            fx_q      <= dx_s[2:0];
            fy_q      <= dy_s[2:0];
            in_map0_q <= in_map_s;
            valid0_q  <= pixel_valid_i;
        end
    end

    // S1 select generation: blank tile when the pixel is off the maze
    always_comb begin
        grid_d = BLANK;
        rot_d  = 2'd0;
        mir_d  = 2'd0;
        xi_d   = 3'd0;
        yi_d   = 3'd0;
        if (in_map0_q) begin
            grid_d = rd_word_q[8:4];
            rot_d  = rd_word_q[3:2];
            mir_d  = rd_word_q[1:0];
            xi_d   = fx_q;
            yi_d   = fy_q;
        end else begin
            grid_d = BLANK;
            rot_d  = 2'd0;
            mir_d  = 2'd0;
            xi_d   = 3'd0;
            yi_d   = 3'd0;
        end
    end

    // S1 register: sprite ROM select lines
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grid_q    <= BLANK;
            rot_q     <= 2'd0;
            mir_q     <= 2'd0;
            xi_q      <= 3'd0;
            yi_q      <= 3'd0;
            in_map1_q <= 1'b0;
            valid1_q  <= 1'b0;
        end else begin
            grid_q    <= grid_d;
            rot_q     <= rot_d;
            mir_q     <= mir_d;
            xi_q      <= xi_d;
            yi_q      <= yi_d;
            in_map1_q <= in_map0_q;
            valid1_q  <= valid0_q;
        end
    end

    // S2 colour select: the ROM answers combinationally to the S1 selects
    always_comb begin
        rgb_d = 12'h000;
        if (in_map1_q) begin
            rgb_d = map_color_i;
        end else begin
            rgb_d = 12'h000;
        end
    end

    // S2 register: final maze colour and its qualifier
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rgb_q  <= 12'h000;
            rgbv_q <= 1'b0;
        end else begin
            rgb_q  <= rgb_d;
            rgbv_q <= valid1_q;
        end
    end

    assign grid_select_o   = grid_q;
    assign rotate_select_o = rot_q;
    assign mirror_select_o = mir_q;
    assign x_index_o       = xi_q;
    assign y_index_o       = yi_q;
    assign rgb_out_o       = rgb_q;
    assign rgb_valid_o     = rgbv_q;

endmodule

// File: tb/tb_map_tile_fetch.sv
// Self-checking bench for map_tile_fetch: vector table, corner sequences and
// a randomized stream checked against a latency-queue reference model.
module tb_map_tile_fetch;

    localparam int COLS  = 28;
    localparam int ROWS  = 31;
    localparam int X0    = 208;
    localparam int Y0    = 116;
    localparam int BLANK = 6;
    localparam int AW    = 10;
    localparam int DEPTH = COLS * ROWS;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    px;
    logic [9:0]    py;
    logic          pv;
    logic          we;
    logic [AW-1:0] wa;
    logic [8:0]    wd;
    logic [4:0]    grid;
    logic [1:0]    rot;
    logic [1:0]    mir;
    logic [2:0]    xi;
    logic [2:0]    yi;
    logic [11:0]   mc;
    logic [11:0]   rgb;
    logic          rgbv;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    map_tile_fetch dut (
        .clk_i(clk), .reset_i(reset),
        .pixel_x_i(px), .pixel_y_i(py), .pixel_valid_i(pv),
        .tile_we_i(we), .tile_waddr_i(wa), .tile_wdata_i(wd),
        .grid_select_o(grid), .rotate_select_o(rot), .mirror_select_o(mir),
        .x_index_o(xi), .y_index_o(yi),
        .map_color_i(mc), .rgb_out_o(rgb), .rgb_valid_o(rgbv)
    );

    // Behavioural sprite ROM: grid 7 is solid white, others encode their inputs
    function automatic logic [11:0] rom(input logic [4:0] g, input logic [1:0] r,
                                        input logic [1:0] m, input logic [2:0] x,
                                        input logic [2:0] y);
        if (g == 5'd7) return 12'hFFF;
        return {g, r, m, x ^ y};
    endfunction

    assign mc = rom(grid, rot, mir, xi, yi);

    typedef struct {
        bit inmap;
        bit v;
        int g, r, m, x, y;
    } rec_t;

    logic [8:0] mem_m [DEPTH];
    rec_t       q[$];

    function automatic rec_t mk(input int x, input int y, input bit v);
        rec_t rr;
        int col, row;
        logic [8:0] w;
        rr.v     = v;
        rr.inmap = v && (x >= X0) && (y >= Y0) && ((x - X0) / 8 < COLS) && ((y - Y0) / 8 < ROWS);
        if (rr.inmap) begin
            col  = (x - X0) / 8;
            row  = (y - Y0) / 8;
            w    = mem_m[row * COLS + col];
            rr.g = int'(w[8:4]);
            rr.r = int'(w[3:2]);
            rr.m = int'(w[1:0]);
            rr.x = (x - X0) % 8;
            rr.y = (y - Y0) % 8;
        end else begin
            rr.g = BLANK; rr.r = 0; rr.m = 0; rr.x = 0; rr.y = 0;
        end
        return rr;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample inputs into the model at the edge, then compare outputs
    task automatic tick();
        int n;
        int exp_sel, exp_rgb, exp_v;
        rec_t rr;
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            q.push_back(mk(int'(px), int'(py), pv));
            if (q.size() > 3) void'(q.pop_front());
        end
        if (we && int'(wa) < DEPTH) mem_m[wa] = wd;
        #1;
        n = q.size();
        exp_sel = {5'(BLANK), 2'd0, 2'd0, 3'd0, 3'd0};
        if (n >= 2) begin
            rr = q[n-2];
            exp_sel = {5'(rr.g), 2'(rr.r), 2'(rr.m), 3'(rr.x), 3'(rr.y)};
        end
        exp_rgb = 0;
        exp_v   = 0;
        if (n >= 3) begin
            rr = q[n-3];
            exp_v = rr.v;
            if (rr.inmap) exp_rgb = rom(5'(rr.g), 2'(rr.r), 2'(rr.m), 3'(rr.x), 3'(rr.y));
        end
        chk("model_sel", {grid, rot, mir, xi, yi}, exp_sel);
        chk("model_rgb", rgb, exp_rgb);
        chk("model_rgbv", rgbv, exp_v);
    endtask

    task automatic wr(input int a, input logic [8:0] d);
        we = 1'b1; wa = AW'(a); wd = d;
        tick();
        we = 1'b0;
    endtask

    typedef struct {
        int x, y;
        bit v;
        int g, r, m, xi, yi, rgb;
        bit rv;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{x:208,  y:121,  v:1, g:7,  r:0, m:0, xi:0, yi:5, rgb:'hFFF, rv:1};
        tbl[1] = '{x:207,  y:116,  v:1, g:6,  r:0, m:0, xi:0, yi:0, rgb:'h000, rv:1};
        tbl[2] = '{x:431,  y:363,  v:1, g:30, r:1, m:1, xi:7, yi:7, rgb:'hF28, rv:1};
        tbl[3] = '{x:432,  y:363,  v:1, g:6,  r:0, m:0, xi:0, yi:0, rgb:'h000, rv:1};
        tbl[4] = '{x:431,  y:364,  v:1, g:6,  r:0, m:0, xi:0, yi:0, rgb:'h000, rv:1};
        tbl[5] = '{x:208,  y:121,  v:0, g:6,  r:0, m:0, xi:0, yi:0, rgb:'h000, rv:0};
        tbl[6] = '{x:0,    y:0,    v:1, g:6,  r:0, m:0, xi:0, yi:0, rgb:'h000, rv:1};
        tbl[7] = '{x:1023, y:1023, v:1, g:6,  r:0, m:0, xi:0, yi:0, rgb:'h000, rv:1};

        we = 1'b0; wa = '0; wd = '0;

        // Reset held two cycles with a live in-map pixel, then three idle cycles
        reset = 1'b1; pv = 1'b1; px = 10'd210; py = 10'd120;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                reset = 1'b0;
                pv    = 1'b0;
            end
            tick();
            chk("rst_rgbv", rgbv, 0);
            chk("rst_rgb", rgb, 0);
            chk("rst_grid", grid, BLANK);
        end

        for (int a = 0; a < DEPTH; a++) wr(a, 9'($urandom));
        wr(0, 9'h070);
        wr(1, 9'h0B6);
        wr(867, 9'h1E5);
        wr(29, 9'h018);

        // Table-driven single-pixel vectors
        for (int i = 0; i < 8; i++) begin
            px = 10'(tbl[i].x); py = 10'(tbl[i].y); pv = tbl[i].v;
            tick();
            px = 10'd0; py = 10'd0; pv = 1'b0;
            tick();
            chk("vec_grid", grid, tbl[i].g);
            chk("vec_rot", rot, tbl[i].r);
            chk("vec_mir", mir, tbl[i].m);
            chk("vec_xi", xi, tbl[i].xi);
            chk("vec_yi", yi, tbl[i].yi);
            tick();
            chk("vec_rgb", rgb, tbl[i].rgb);
            chk("vec_rgbv", rgbv, tbl[i].rv);
        end

        // Read/write collision on addr 29 returns the old word
        px = 10'd216; py = 10'd124; pv = 1'b1;
        we = 1'b1; wa = AW'(29); wd = 9'h1FF;
        tick();
        we = 1'b0; pv = 1'b0;
        tick();
        chk("coll_grid", grid, 1);
        chk("coll_rot", rot, 2);
        tick();
        pv = 1'b1;
        tick();
        pv = 1'b0;
        tick();
        chk("new_grid", grid, 31);
        chk("new_rot", rot, 3);
        chk("new_mir", mir, 3);
        wr(900, 9'h000);
        px = 10'd216; py = 10'd124; pv = 1'b1;
        tick();
        px = 10'd208; py = 10'd116;
        tick();
        chk("oob_wr_grid29", grid, 31);
        pv = 1'b0;
        tick();
        chk("oob_wr_grid0", grid, 7);

        // Streaming across the tile 0 / tile 1 boundary with no bubbles
        py = 10'd116;
        for (int i = 0; i <= 16; i++) begin
            px = 10'(208 + (i % 16));
            pv = (i < 16);
            tick();
            if (i >= 1) begin
                chk("strm_xi", xi, (i - 1) % 8);
                chk("strm_grid", grid, (i - 1) < 8 ? 7 : 11);
            end
        end

        // Mid-stream single-cycle reset
        for (int i = 0; i < 20; i++) begin
            px = 10'(208 + (i % 16));
            pv = (i < 16);
            reset = (i == 5);
            tick();
            if (i >= 5 && i <= 7) chk("mrst_rgbv0", rgbv, 0);
            if (i == 8) chk("mrst_rgbv1", rgbv, 1);
        end
        reset = 1'b0;

        // Randomized stream with concurrent writes and rare resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                px = 10'($urandom);
                py = 10'($urandom);
            end else begin
                px = 10'($urandom_range(195, 445));
                py = 10'($urandom_range(105, 375));
            end
            pv    = ($urandom_range(0, 7) != 0);
            we    = ($urandom_range(0, 3) == 0);
            wa    = AW'($urandom_range(0, 1023));
            wd    = 9'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; we = 1'b0; pv = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
